e203_sysper_dma: RTL and testbench
==================================

// Module: e203_sysper_dma
// PURPOSE
// - ICB responder on core sysper bus; 4 config/status regs.
// - Word-copy engine: ICB initiator into ext2dtcm port, copies LEN words SRC->DST.
// - Strictly one outstanding master transaction (read, then write, per word).
// PARAMETERS
// - AW  32  ICB address width, both ports.
// - LW  16  LEN register width (max words per job = 2^LW-1).
// PORTS
// - clk          in   1   core clock.
// - rst_n        in   1   async active-low reset.
// - s_icb_cmd_valid/ready  in/out 1; s_icb_cmd_read in 1; s_icb_cmd_addr in AW; s_icb_cmd_wdata in 32; s_icb_cmd_wmask in 4.
// - s_icb_rsp_valid out 1; s_icb_rsp_ready in 1; s_icb_rsp_err out 1; s_icb_rsp_rdata out 32.
// - m_icb_cmd_valid out 1; m_icb_cmd_ready in 1; m_icb_cmd_read out 1; m_icb_cmd_addr out AW; m_icb_cmd_wdata out 32; m_icb_cmd_wmask out 4.
// - m_icb_rsp_valid in 1; m_icb_rsp_ready out 1; m_icb_rsp_err in 1; m_icb_rsp_rdata in 32.
// - irq          out  1   completion interrupt (see CONFIGURATION).
// BEHAVIOUR
// - Reset: all regs 0; FSM IDLE; s_icb_rsp_valid=0, m_icb_cmd_valid=0, m_icb_rsp_ready=0, irq=0.
// - Reg map, decode addr[3:2]: 0 SRC, 1 DST, 2 LEN[LW-1:0], 3 CTRL.
// - CTRL: b0 START (write 1, reads 0); b1 BUSY (RO); b2 DONE (W1C); b3 ERR (W1C); b4 IE (RW).
// - Slave: cmd_ready = ~s_icb_rsp_valid | s_icb_rsp_ready; rsp one cycle after cmd handshake.
//   rsp_err=0 always; wmask ignored (full-word writes). rdata of unused bits = 0.
// - Writes to SRC/DST/LEN while BUSY: dropped, still responded.
// - START when BUSY=0: latch cur_src/cur_dst/cnt; clear DONE/ERR; BUSY=1 next cycle.
// - START when BUSY=1: ignored. START with LEN=0: DONE=1 next cycle, no master traffic.
// - FSM: IDLE -> RD_CMD -> RD_RSP -> WR_CMD -> WR_RSP -> RD_CMD (cnt>1) | IDLE (cnt==1).
//   RD_CMD: cmd_valid=1, read=1, addr=cur_src; hold stable until cmd_ready.
//   RD_RSP: rsp_ready=1; capture rdata on rsp_valid.
//   WR_CMD: cmd_valid=1, read=0, addr=cur_dst, wdata=captured, wmask=4'hF.
//   WR_RSP: rsp_ready=1; on rsp_valid: cur_src+=4, cur_dst+=4, cnt-=1.
// - Address increment wraps mod 2^AW, no error.
// - m_icb_rsp_err=1 in either RSP state: abort to IDLE, ERR=1, DONE=1, BUSY=0.
// - Completion: BUSY falls and DONE rises same cycle as last WR_RSP handshake.
// - SRC/DST regs are not updated by engine; BUSY readback shows live state.
// - Async reset mid-job: master cmd_valid drops immediately; job lost; no resume.
// - Slave access and master activity are independent; same-cycle START + DONE W1C: START wins (DONE=0).
// CONFIGURATION
// - Macro E203_SYSPER_DMA_IRQ_EN.
// - Defined: irq = DONE & IE, registered-level, cleared by W1C of DONE.
// - Undefined: IE bit reads 0, writes ignored; irq tied 0.
// TESTING
// - Write SRC=0x100,DST=0x200,LEN=4,START -> 4 reads 0x100..0x10C, 4 writes 0x200..0x20C, data match, DONE=1, BUSY=0.
// - LEN=0 START -> zero m_icb_cmd_valid cycles; CTRL reads 0x4 next access.
// - Inject m_icb_rsp_err on 2nd read -> no 2nd write issued; CTRL reads 0xC; W1C 0xC -> reads 0x0.
// - Random m_icb_cmd_ready/s_icb_rsp_ready backpressure -> addr/wdata stable while valid&~ready; no lost/duplicated rsp.
// - START + DST write while BUSY -> ignored; original job finishes with original DST.
// - IRQ_EN: IE=1, LEN=1 -> irq rises with DONE; W1C DONE -> irq=0. Without macro irq stays 0.
// - Assert rst_n low in WR_CMD -> m_icb_cmd_valid=0 same cycle; all regs 0 after release.

Source files
------------

// File: rtl/e203_sysper_dma_if.sv
// ICB command/response bundle shared by the sysper responder port and the copy-engine initiator port.
// The master modport is the side that issues commands; slave is the side that answers them.
interface e203_sysper_dma_if #(
  parameter int AW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_err;
  logic [31:0]   rsp_rdata;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/e203_sysper_dma.sv
// Sysper-bus register block driving a one-word-at-a-time ICB copy engine (read, then write, per word).
// Optional completion interrupt is built in when E203_SYSPER_DMA_IRQ_EN is defined.
module e203_sysper_dma #(
  parameter int AW = 32,
  parameter int LW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  e203_sysper_dma_if.slave  s_icb,
  e203_sysper_dma_if.master m_icb,
  output logic              irq
);
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP} state_t;
  state_t state_reg, state_next;

  logic [AW-1:0] src_reg, dst_reg, cur_src_reg, cur_dst_reg;
  logic [LW-1:0] len_reg, cnt_reg;
  logic [31:0]   buf_reg, s_rdata_reg, rd_data;
  logic          done_reg, err_reg, s_rsp_valid_reg, ie_bit;
  logic          busy, s_hs, s_wr, ctrl_wr, start, start_job;
  logic          m_rsp_hs, abort, finish;
  logic [1:0]    reg_sel;
  logic          unused_bits;

  assign busy      = (state_reg != IDLE);
  assign reg_sel   = s_icb.cmd_addr[3:2];
  assign s_icb.cmd_ready = ~s_rsp_valid_reg | s_icb.rsp_ready;
  assign s_hs      = s_icb.cmd_valid & s_icb.cmd_ready;
  assign s_wr      = s_hs & ~s_icb.cmd_read;
  assign ctrl_wr   = s_wr & (reg_sel == 2'd3);
  assign start     = ctrl_wr & s_icb.cmd_wdata[0] & ~busy;
  assign start_job = start & (len_reg != '0);

  // rsp_ready is only high in the two RSP states, so a response handshake implies one of them
  assign m_rsp_hs = m_icb.rsp_valid & m_icb.rsp_ready;
  assign abort    = m_rsp_hs & m_icb.rsp_err;
  assign finish   = m_rsp_hs & ~m_icb.rsp_err & (state_reg == WR_RSP) & (cnt_reg == LW'(1));

  // Byte masks and the address bits outside the register decode carry no meaning here
  assign unused_bits = ^{s_icb.cmd_wmask, s_icb.cmd_addr[AW-1:4], s_icb.cmd_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Master outputs decode from state only, so an async reset drops cmd_valid immediately
  always_comb begin
    state_next        = state_reg;
    m_icb.cmd_valid   = 1'b0;
    m_icb.cmd_read    = 1'b0;
    m_icb.cmd_addr    = cur_dst_reg;
    m_icb.cmd_wdata   = buf_reg;
    m_icb.cmd_wmask   = 4'hF;
    m_icb.rsp_ready   = 1'b0;
    case (state_reg)
      IDLE: if (start_job) state_next = RD_CMD;
      RD_CMD: begin
        m_icb.cmd_valid = 1'b1;
        m_icb.cmd_read  = 1'b1;
        m_icb.cmd_addr  = cur_src_reg;
        if (m_icb.cmd_ready) state_next = RD_RSP;
      end
      RD_RSP: begin
        m_icb.rsp_ready = 1'b1;
        if (m_icb.rsp_valid) state_next = m_icb.rsp_err ? IDLE : WR_CMD;
      end
      WR_CMD: begin
        m_icb.cmd_valid = 1'b1;
        if (m_icb.cmd_ready) state_next = WR_RSP;
      end
      WR_RSP: begin
        m_icb.rsp_ready = 1'b1;
        if (m_icb.rsp_valid)
          state_next = (m_icb.rsp_err || cnt_reg == LW'(1)) ? IDLE : RD_CMD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_src_reg <= '0;
      cur_dst_reg <= '0;
      cnt_reg     <= '0;
      buf_reg     <= '0;
    end else begin
      if (start_job) begin
        cur_src_reg <= src_reg;
        cur_dst_reg <= dst_reg;
        cnt_reg     <= len_reg;
      end
      if (state_reg == RD_RSP && m_icb.rsp_valid) buf_reg <= m_icb.rsp_rdata;
      if (state_reg == WR_RSP && m_icb.rsp_valid && !m_icb.rsp_err) begin
        cur_src_reg <= cur_src_reg + AW'(4);
        cur_dst_reg <= cur_dst_reg + AW'(4);
        cnt_reg     <= cnt_reg - LW'(1);
      end
    end
  end

  // Job setup registers are frozen while a copy runs; the access is still answered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg <= '0;
      dst_reg <= '0;
      len_reg <= '0;
    end else if (s_wr && !busy) begin
      case (reg_sel)
        2'd0:    src_reg <= s_icb.cmd_wdata[AW-1:0];
        2'd1:    dst_reg <= s_icb.cmd_wdata[AW-1:0];
        2'd2:    len_reg <= s_icb.cmd_wdata[LW-1:0];
        default: ;
      endcase
    end
  end

  // START clears stale status, so it outranks a DONE/ERR clear carried in the same write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else if (start) begin
      done_reg <= (len_reg == '0);
      err_reg  <= 1'b0;
    end else begin
      if (ctrl_wr && s_icb.cmd_wdata[2]) done_reg <= 1'b0;
      if (ctrl_wr && s_icb.cmd_wdata[3]) err_reg  <= 1'b0;
      if (abort) begin
        done_reg <= 1'b1;
        err_reg  <= 1'b1;
      end
      if (finish) done_reg <= 1'b1;
    end
  end

`ifdef E203_SYSPER_DMA_IRQ_EN
  logic ie_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ie_reg <= 1'b0;
    else if (ctrl_wr) ie_reg <= s_icb.cmd_wdata[4];
  end
  assign ie_bit = ie_reg;
  // Both terms are flops, so the level follows DONE and drops on its W1C
  assign irq    = done_reg & ie_reg;
`else
  assign ie_bit = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      2'd0:    rd_data[AW-1:0] = src_reg;
      2'd1:    rd_data[AW-1:0] = dst_reg;
      2'd2:    rd_data[LW-1:0] = len_reg;
      default: rd_data[4:0]    = {ie_bit, err_reg, done_reg, busy, 1'b0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rsp_valid_reg <= 1'b0;
      s_rdata_reg     <= '0;
    end else if (s_hs) begin
      s_rsp_valid_reg <= 1'b1;
      s_rdata_reg     <= s_icb.cmd_read ? rd_data : 32'h0;
    end else if (s_icb.rsp_ready) begin
      s_rsp_valid_reg <= 1'b0;
    end
  end

  assign s_icb.rsp_valid = s_rsp_valid_reg;
  assign s_icb.rsp_err   = 1'b0;
  assign s_icb.rsp_rdata = s_rdata_reg;

endmodule

// File: tb/tb_e203_sysper_dma.sv
// Bench for e203_sysper_dma: register table plus copy jobs checked against a master-side scoreboard.
// Build with E203_SYSPER_DMA_IRQ_EN defined to exercise the interrupt path.
module tb_e203_sysper_dma;
  localparam int AW = 32;
`ifdef E203_SYSPER_DMA_IRQ_EN
  localparam logic [31:0] IRQ_ON = 32'h1;
`else
  localparam logic [31:0] IRQ_ON = 32'h0;
`endif
  localparam logic [31:0] IE_RB = IRQ_ON << 4;

  logic clk = 1'b0;
  logic rst_n;
  logic irq;
  always #5 clk = ~clk;

  e203_sysper_dma_if #(.AW(AW)) s_bus ();
  e203_sysper_dma_if #(.AW(AW)) m_bus ();

  e203_sysper_dma #(.AW(AW), .LW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_icb (s_bus),
    .m_icb (m_bus),
    .irq   (irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- master-side memory model and scoreboard ----------------
  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
  } mtxn_t;

  mtxn_t       m_exp_q[$];
  mtxn_t       m_t;
  logic [31:0] mem [logic [31:0]];
  bit          bp = 0;
  bit          hold_wr = 0;
  int          read_cnt = 0;
  int          err_at = 0;
  int          valid_cycles = 0;
  bit          pend, pend_err, stall_seen;
  logic [31:0] pend_data, stall_addr, stall_wdata;
  logic        stall_rd;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_DEAD;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
      pend_err = 0;
      pend_data = '0;
      stall_seen = 0;
      m_bus.cmd_ready = 1'b0;
      m_bus.rsp_valid = 1'b0;
      m_bus.rsp_err = 1'b0;
      m_bus.rsp_rdata = '0;
    end else begin
      if (m_bus.cmd_valid) valid_cycles++;
      if (hold_wr && m_bus.cmd_valid && !m_bus.cmd_read) m_bus.cmd_ready = 1'b0;
      else m_bus.cmd_ready = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
      m_bus.rsp_valid = pend && (!bp || $urandom_range(0, 1) == 1);
      m_bus.rsp_err   = pend_err;
      m_bus.rsp_rdata = pend_data;
      if (stall_seen) begin
        check("stall_valid", {31'b0, m_bus.cmd_valid}, 32'h1);
        check("stall_read", {31'b0, m_bus.cmd_read}, {31'b0, stall_rd});
        check("stall_addr", m_bus.cmd_addr, stall_addr);
        if (!stall_rd) check("stall_wdata", m_bus.cmd_wdata, stall_wdata);
      end
      stall_seen  = m_bus.cmd_valid && !m_bus.cmd_ready;
      stall_rd    = m_bus.cmd_read;
      stall_addr  = m_bus.cmd_addr;
      stall_wdata = m_bus.cmd_wdata;
      if (m_bus.rsp_valid && m_bus.rsp_ready) pend = 0;
      if (m_bus.cmd_valid && m_bus.cmd_ready) begin
        $display("M %s addr=%08h wdata=%08h", m_bus.cmd_read ? "RD" : "WR",
                 m_bus.cmd_addr, m_bus.cmd_wdata);
        if (m_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got read=%0d addr 0x%08h, required no command",
                   m_bus.cmd_read, m_bus.cmd_addr);
        end else begin
          m_t = m_exp_q.pop_front();
          check("m_read", {31'b0, m_bus.cmd_read}, {31'b0, m_t.rd});
          check("m_addr", m_bus.cmd_addr, m_t.addr);
          if (!m_t.rd) begin
            check("m_wdata", m_bus.cmd_wdata, m_t.data);
            check("m_wmask", {28'b0, m_bus.cmd_wmask}, 32'hF);
          end
        end
        pend = 1;
        if (m_bus.cmd_read) begin
          read_cnt++;
          pend_err  = (read_cnt == err_at);
          pend_data = mem_rd(m_bus.cmd_addr);
        end else begin
          mem[m_bus.cmd_addr] = m_bus.cmd_wdata;
          pend_err  = 0;
          pend_data = '0;
        end
      end
    end
  end

  // ---------------- slave-side access task with response scoreboard ----------------
  typedef struct {
    bit          rd;
    bit          chk;
    logic [31:0] exp;
    string       name;
  } sexp_t;

  sexp_t s_exp_q[$];

  task automatic reg_access(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit chk, input logic [31:0] exp, input string name,
                            output logic [31:0] rdata);
    sexp_t e;
    int    n;
    e.rd = rd; e.chk = chk; e.exp = exp; e.name = name;
    s_exp_q.push_back(e);
    rdata = '0;
    @(negedge clk);
    s_bus.cmd_valid = 1'b1;
    s_bus.cmd_read  = rd;
    s_bus.cmd_addr  = addr;
    s_bus.cmd_wdata = wdata;
    s_bus.cmd_wmask = rd ? 4'hF : 4'($urandom);
    n = 0;
    while (!s_bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL s_cmd_timeout %s: got cmd_ready=0, required 1", name);
    end
    @(negedge clk);
    s_bus.cmd_valid = 1'b0;
    n = 0;
    s_bus.rsp_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    while (!(s_bus.rsp_valid && s_bus.rsp_ready) && n < 50) begin
      @(negedge clk);
      s_bus.rsp_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      n++;
    end
    e = s_exp_q.pop_front();
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL s_rsp_timeout %s: got no response, required one", name);
    end else begin
      rdata = s_bus.rsp_rdata;
      check("s_rsp_err", {31'b0, s_bus.rsp_err}, 32'h0);
      if (e.chk && e.rd) check(e.name, rdata, e.exp);
      $display("S %s addr=%08h wdata=%08h rdata=%08h", rd ? "RD" : "WR", addr, wdata, rdata);
    end
    @(negedge clk);
    s_bus.rsp_ready = 1'b0;
    check("s_rsp_single", {31'b0, s_bus.rsp_valid}, 32'h0);
  endtask

  task automatic reg_wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    reg_access(1'b0, addr, wdata, 1'b0, 32'h0, "wr", d);
  endtask

  task automatic reg_chk(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] d;
    reg_access(1'b1, addr, 32'h0, 1'b1, exp, name, d);
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    bit idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      reg_access(1'b1, 32'hC, 32'h0, 1'b0, 32'h0, "poll", v);
      idle = (v[1] == 1'b0);
    end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got BUSY=1 after 200 polls, required 0");
    end
  endtask

  // err_word: 1-based read index that returns an error, 0 for none
  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int len,
                         input int err_word, input logic [31:0] ctrl);
    mtxn_t t;
    logic [31:0] d;
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      mem[src + 32'(4 * i)] = d;
      t.rd = 1; t.addr = src + 32'(4 * i); t.data = d;
      m_exp_q.push_back(t);
      if (err_word == i + 1) break;
      t.rd = 0; t.addr = dst + 32'(4 * i); t.data = d;
      m_exp_q.push_back(t);
    end
    err_at = (err_word != 0) ? read_cnt + err_word : 0;
    reg_wr(32'h0, src);
    reg_wr(32'h4, dst);
    reg_wr(32'h8, 32'(len));
    reg_wr(32'hC, ctrl);
  endtask

  task automatic check_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    for (int i = 0; i < len; i++)
      check("copy_word", mem_rd(dst + 32'(4 * i)), mem_rd(src + 32'(4 * i)));
  endtask

  // ---------------- register table ----------------
  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] d;
    int n;
    int vc;

    tbl[0]  = '{1'b1, 32'h0,  32'h0,         32'h0,         "rst_src"};
    tbl[1]  = '{1'b1, 32'h4,  32'h0,         32'h0,         "rst_dst"};
    tbl[2]  = '{1'b1, 32'h8,  32'h0,         32'h0,         "rst_len"};
    tbl[3]  = '{1'b1, 32'hC,  32'h0,         32'h0,         "rst_ctrl"};
    tbl[4]  = '{1'b0, 32'h0,  32'hDEADBEEF,  32'h0,         "wr_src"};
    tbl[5]  = '{1'b1, 32'h0,  32'h0,         32'hDEADBEEF,  "src_rw"};
    tbl[6]  = '{1'b0, 32'h4,  32'h12345678,  32'h0,         "wr_dst"};
    tbl[7]  = '{1'b1, 32'h14, 32'h0,         32'h12345678,  "dst_alias"};
    tbl[8]  = '{1'b0, 32'h8,  32'hFFFF1234,  32'h0,         "wr_len"};
    tbl[9]  = '{1'b1, 32'h8,  32'h0,         32'h00001234,  "len_trunc"};
    tbl[10] = '{1'b0, 32'hC,  32'h0000001C,  32'h0,         "wr_ctrl_ie"};
    tbl[11] = '{1'b1, 32'hC,  32'h0,         IE_RB,         "ctrl_ie"};
    tbl[12] = '{1'b0, 32'hC,  32'h0,         32'h0,         "wr_ctrl_0"};
    tbl[13] = '{1'b1, 32'hC,  32'h0,         32'h0,         "ctrl_ie_clr"};

    s_bus.cmd_valid = 1'b0;
    s_bus.cmd_read  = 1'b0;
    s_bus.cmd_addr  = '0;
    s_bus.cmd_wdata = '0;
    s_bus.cmd_wmask = '0;
    s_bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_m_valid", {31'b0, m_bus.cmd_valid}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      reg_access(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].exp, tbl[i].name, d);

    // Basic 4-word copy
    run_job(32'h100, 32'h200, 4, 0, 32'h1);
    reg_chk(32'hC, 32'h2, "busy_rd");
    wait_idle();
    reg_chk(32'hC, 32'h4, "job1_done");
    check("job1_all_txns", m_exp_q.size(), 0);
    check_copy(32'h100, 32'h200, 4);

    // START and DST writes while busy are dropped
    run_job(32'h300, 32'h400, 3, 0, 32'h1);
    reg_wr(32'h4, 32'h800);
    reg_wr(32'hC, 32'h1);
    reg_chk(32'h4, 32'h400, "dst_locked");
    wait_idle();
    reg_chk(32'hC, 32'h4, "job2_done");
    reg_chk(32'h0, 32'h300, "src_unchanged");
    check("job2_all_txns", m_exp_q.size(), 0);
    check_copy(32'h300, 32'h400, 3);

    // LEN=0: completes with no master traffic
    vc = valid_cycles;
    reg_wr(32'h8, 32'h0);
    reg_wr(32'hC, 32'h5);
    reg_chk(32'hC, 32'h4, "len0_done");
    check("len0_no_traffic", valid_cycles - vc, 0);

    // START together with DONE W1C: START wins, DONE stays clear while busy
    run_job(32'h500, 32'h600, 2, 0, 32'h5);
    reg_chk(32'hC, 32'h2, "start_w1c");
    wait_idle();
    reg_chk(32'hC, 32'h4, "job4_done");
    check("job4_all_txns", m_exp_q.size(), 0);

    // Error on second read aborts before the second write
    run_job(32'h700, 32'h780, 4, 2, 32'h1);
    wait_idle();
    repeat (4) @(negedge clk);
    reg_chk(32'hC, 32'hC, "err_ctrl");
    check("err_no_wr2", m_exp_q.size(), 0);
    reg_wr(32'hC, 32'hC);
    reg_chk(32'hC, 32'h0, "err_w1c");
    err_at = 0;

    // Random backpressure on both ports, source address wrapping past 2^32
    bp = 1;
    run_job(32'hFFFF_FFF8, 32'h1000, 6, 0, 32'h1);
    wait_idle();
    reg_chk(32'hC, 32'h4, "bp_done");
    check("bp_all_txns", m_exp_q.size(), 0);
    check_copy(32'hFFFF_FFF8, 32'h1000, 6);
    bp = 0;

    // Completion interrupt
    reg_wr(32'hC, 32'h14);
    check("irq_idle", {31'b0, irq}, 32'h0);
    run_job(32'h1100, 32'h1200, 1, 0, 32'h11);
    wait_idle();
    check("irq_set", {31'b0, irq}, IRQ_ON);
    reg_chk(32'hC, 32'h4 | IE_RB, "irq_ctrl");
    reg_wr(32'hC, 32'h14);
    check("irq_clr", {31'b0, irq}, 32'h0);
    reg_chk(32'hC, IE_RB, "irq_ctrl_clr");

    // Async reset while a write command is stalled
    hold_wr = 1;
    run_job(32'h1300, 32'h1400, 4, 0, 32'h1);
    n = 0;
    while (!(m_bus.cmd_valid && !m_bus.cmd_read) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_wr_cmd", {31'b0, n < 100}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_valid_drop", {31'b0, m_bus.cmd_valid}, 32'h0);
    check("rst_irq_mid", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    m_exp_q.delete();
    hold_wr = 0;
    vc = valid_cycles;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      reg_access(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].exp, tbl[i].name, d);
    repeat (5) @(negedge clk);
    check("no_resume", valid_cycles - vc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
